conv_window_buffer: RTL



---
 rtl/conv_pkg.sv | 9 +
 rtl/line_buffer.sv | 25 ++
 rtl/conv_window_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared defaults and pixel type for the convolution datapath (window buffer and adder tree).
package conv_pkg;
    localparam int unsigned BITWIDTH     = 8;
    localparam int unsigned FILTER_WIDTH = 3;
    localparam int unsigned IMAGE_WIDTH  = 28;
    localparam int unsigned IMAGE_HEIGHT = 28;

    typedef logic [BITWIDTH-1:0] pixel_t;
endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: asynchronous read and synchronous write at the same column index.
module line_buffer #(
    parameter int unsigned bitwidth = 8,
    parameter int unsigned depth    = 28,
    parameter int unsigned idx_w    = $clog2(depth)
) (
    input  logic                clock,
    input  logic                we,
    input  logic [idx_w-1:0]    idx,
    input  logic [bitwidth-1:0] wr_data,
    output logic [bitwidth-1:0] rd_data_c
);

    // Contents are never cleared; the owner gates stale rows out by position.
    logic [bitwidth-1:0] mem_q [depth];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[idx] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[idx];

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-stream sliding-window generator: line buffers plus a window shift register,
// emitting each unpadded filterWidth x filterWidth window with a stall-capable valid strobe.
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int unsigned bitwidth    = BITWIDTH,
    parameter int unsigned filterWidth = FILTER_WIDTH,
    parameter int unsigned imageWidth  = IMAGE_WIDTH,
    parameter int unsigned imageHeight = IMAGE_HEIGHT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [bitwidth-1:0] pixelIn,
    input  logic                pixelValid,
    output logic                pixelReady,
    output logic [bitwidth-1:0] window [filterWidth-1:0][0:filterWidth-1],
    output logic                windowValid,
    input  logic                windowAccept,
    output logic                frameDone
);

    localparam int unsigned COL_W = $clog2(imageWidth);
    localparam int unsigned ROW_W = $clog2(imageHeight);
    localparam int unsigned LAST  = filterWidth - 1;

    logic [bitwidth-1:0] win_q [filterWidth-1:0][0:filterWidth-1];
    logic [bitwidth-1:0] win_d [filterWidth-1:0][0:filterWidth-1];
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                accept_c;
    logic [bitwidth-1:0] lb_rd_c [filterWidth-1];

    // Buffer 0 holds the oldest row; each accept shifts the column down one buffer.
    for (genvar r = 0; r < filterWidth - 1; r++) begin : g_lb
        logic [bitwidth-1:0] wr_data;
        if (r == filterWidth - 2) begin : g_last
            assign wr_data = pixelIn;
        end else begin : g_mid
            assign wr_data = lb_rd_c[r+1];
        end

        line_buffer #(
            .bitwidth (bitwidth),
            .depth    (imageWidth),
            .idx_w    (COL_W)
        ) u_lb (
            .clock     (clock),
            .we        (accept_c),
            .idx       (col_q),
            .wr_data   (wr_data),
            .rd_data_c (lb_rd_c[r])
        );
    end

    always_comb begin
        win_d      = win_q;
        col_d      = col_q;
        row_d      = row_q;
        valid_d    = valid_q;
        done_d     = done_q;
        pixelReady = !valid_q || windowAccept;
        accept_c   = pixelValid && pixelReady;

        if (accept_c) begin
            for (int unsigned r = 0; r < filterWidth; r++) begin
                for (int unsigned c = 0; c < LAST; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int unsigned r = 0; r < LAST; r++) begin
                win_d[r][LAST] = lb_rd_c[r];
            end
            win_d[LAST][LAST] = pixelIn;

            valid_d = (row_q >= ROW_W'(LAST)) && (col_q >= COL_W'(LAST));
            done_d  = valid_d && (row_q == ROW_W'(imageHeight - 1))
                              && (col_q == COL_W'(imageWidth - 1));

            if (col_q == COL_W'(imageWidth - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(imageHeight - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else if (windowAccept) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned r = 0; r < filterWidth; r++) begin
                for (int unsigned c = 0; c < filterWidth; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            win_q   <= win_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < filterWidth; r++) begin
            for (int unsigned c = 0; c < filterWidth; c++) begin
                window[r][c] = win_q[r][c];
            end
        end
    end

    assign windowValid = valid_q;
    assign frameDone   = done_q;

endmodule
